// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared operation encoding and segment sizing for the pipelined add/sub
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand and result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/addsub_segment.sv
// rtl/addsub_segment.sv - SEG-bit ripple-carry segment built from full-adder cells
module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[SEG];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - elastic add/sub with the carry chain split into STAGES registered segments
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_addsub_if.slave bus
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign is_sub = (bus.in_sub == OP_SUB);
    assign b_eff  = bus.in_b ^ {WIDTH{is_sub}};
    assign c0     = bus.in_cin ^ is_sub;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vin;
    logic [STAGES:0]   load;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        load         = '0;
        vin          = '0;
        load[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = ~vld[k] | load[k + 1];
        end
        vin[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = vld[k - 1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= vin[k];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld[STAGES - 1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still waiting for their segment; the last stage has none left.
        localparam int REM = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]         seg_a;
        logic [SEG-1:0]         seg_b;
        logic [SEG-1:0]         seg_sum;
        logic                   seg_cin;
        logic                   seg_cout;
        logic [(k+1)*SEG-1:0]   sum_d;
        logic [(k+1)*SEG-1:0]   sum_q;
        logic                   c_q;
        logic                   en;

        assign en = load[k] & vin[k];

        if (k == 0) begin : g_src
            assign seg_a   = bus.in_a[SEG-1:0];
            assign seg_b   = b_eff[SEG-1:0];
            assign seg_cin = c0;
            assign sum_d   = seg_sum;
        end else begin : g_mid
            assign seg_a   = g_stage[k-1].g_rem.a_rem[SEG-1:0];
            assign seg_b   = g_stage[k-1].g_rem.b_rem[SEG-1:0];
            assign seg_cin = g_stage[k-1].c_q;
            assign sum_d   = {seg_sum, g_stage[k-1].sum_q};
        end

        addsub_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (seg_a),
            .b    (seg_b),
            .cin  (seg_cin),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (en) begin
                sum_q <= sum_d;
                c_q   <= seg_cout;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_rem;
            logic [REM-1:0] b_rem;

            if (k == 0) begin : g_first
                assign a_d = bus.in_a[WIDTH-1:SEG];
                assign b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_next
                assign a_d = g_stage[k-1].g_rem.a_rem[REM+SEG-1:SEG];
                assign b_d = g_stage[k-1].g_rem.b_rem[REM+SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_rem <= '0;
                    b_rem <= '0;
                end else if (en) begin
                    a_rem <= a_d;
                    b_rem <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_q;

            // Same-sign operands producing a result of the other sign.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (seg_a[SEG-1] == seg_b[SEG-1]) && (seg_sum[SEG-1] != seg_a[SEG-1]);
                end
            end
        end
    end

    assign bus.out_sum  = g_stage[STAGES-1].sum_q;
    assign bus.out_cout = g_stage[STAGES-1].c_q;
    assign bus.out_ovf  = g_stage[STAGES-1].g_last.ovf_q;
    assign bus.out_zero = (bus.out_sum == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub in three width/depth configurations
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) if32 ();
    pipelined_addsub_if #(.WIDTH(16)) if16 ();
    pipelined_addsub_if #(.WIDTH(64)) if64 ();

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u32 (.clk(clk), .rst(rst), .bus(if32));
    pipelined_addsub #(.WIDTH(16), .STAGES(1)) u16 (.clk(clk), .rst(rst), .bus(if16));
    pipelined_addsub #(.WIDTH(64), .STAGES(8)) u64 (.clk(clk), .rst(rst), .bus(if64));

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int outs32 = 0;
    bit lat_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to the modular sum and flags.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        logic signed [67:0] md, ua, ub, sa, sb, c, ru, rs, res;
        md = 68'sd1 <<< w;
        ua = a & (md - 68'sd1);
        ub = b & (md - 68'sd1);
        c  = cin;
        sa = ua[w-1] ? ua - md : ua;
        sb = ub[w-1] ? ub - md : ub;
        if (sub) begin
            ru     = ua - ub - c;
            rs     = sa - sb - c;
            e.cout = (ru >= 68'sd0);
        end else begin
            ru     = ua + ub + c;
            rs     = sa + sb + c;
            e.cout = (ru >= md);
        end
        res    = ru & (md - 68'sd1);
        e.sum  = res[63:0];
        e.ovf  = (rs < -(md >>> 1)) || (rs >= (md >>> 1));
        e.zero = (e.sum == 64'd0);
        e.cyc  = cyc;
        e.lat  = lat_en;
        return e;
    endfunction

    task automatic sb(input int id, input int w, input int s, input bit acc,
                      input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                      input bit xfer, input logic [63:0] sum, input logic cout, input logic ovf,
                      input logic zero);
        exp_t e;
        int   n;
        string t;
        t = $sformatf("w%0d", w);
        if (xfer) begin
            n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
            check({t, "_expected_beat"}, 64'(n != 0), 64'd1);
            if (n != 0) begin
                case (id)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check({t, "_sum"},  sum,  e.sum);
                check({t, "_cout"}, 64'(cout), 64'(e.cout));
                check({t, "_ovf"},  64'(ovf),  64'(e.ovf));
                check({t, "_zero"}, 64'(zero), 64'(e.zero));
                if (e.lat) check({t, "_latency"}, 64'(cyc - e.cyc), 64'(s));
            end
            if (id == 0) outs32++;
        end
        if (acc) begin
            e = model(w, a, b, cin, sub);
            case (id)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            sb(0, 32, 4, if32.in_valid && if32.in_ready, 64'(if32.in_a), 64'(if32.in_b),
               if32.in_cin, if32.in_sub, if32.out_valid && if32.out_ready, 64'(if32.out_sum),
               if32.out_cout, if32.out_ovf, if32.out_zero);
            sb(1, 16, 1, if16.in_valid && if16.in_ready, 64'(if16.in_a), 64'(if16.in_b),
               if16.in_cin, if16.in_sub, if16.out_valid && if16.out_ready, 64'(if16.out_sum),
               if16.out_cout, if16.out_ovf, if16.out_zero);
            sb(2, 64, 8, if64.in_valid && if64.in_ready, if64.in_a, if64.in_b,
               if64.in_cin, if64.in_sub, if64.out_valid && if64.out_ready, if64.out_sum,
               if64.out_cout, if64.out_ovf, if64.out_zero);
        end
    end

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        if32.in_a     = a;
        if32.in_b     = b;
        if32.in_cin   = cin;
        if32.in_sub   = sub;
        if32.in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = if32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if32.in_valid = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic run_one32(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub, input logic [31:0] es,
                             input logic ec, input logic eo, input logic ez);
        int n;
        bit seen;
        send32(a, b, cin, sub);
        n    = 0;
        seen = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (if32.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_seen"},    64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_sum"},     64'(if32.out_sum), 64'(es));
        check({tag, "_cout"},    64'(if32.out_cout), 64'(ec));
        check({tag, "_ovf"},     64'(if32.out_ovf), 64'(eo));
        check({tag, "_zero"},    64'(if32.out_zero), 64'(ez));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(7))
            0:       return 64'd0;
            1:       return '1;
            2:       return {1'b1, 63'd0};
            3:       return {1'b0, {63{1'b1}}};
            4:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rand_phase(input int cycles, input bit rand_ready);
        logic [63:0] a, b;
        logic        cin, sub, v, r;
        for (int i = 0; i < cycles; i++) begin
            a   = rnd64();
            b   = rnd64();
            cin = 1'($urandom);
            sub = 1'($urandom);
            v   = ($urandom_range(4) != 0);
            r   = rand_ready ? ($urandom_range(2) != 0) : 1'b1;
            if32.in_a = a[31:0]; if32.in_b = b[31:0]; if32.in_cin = cin; if32.in_sub = sub;
            if16.in_a = a[15:0]; if16.in_b = b[15:0]; if16.in_cin = cin; if16.in_sub = sub;
            if64.in_a = a;       if64.in_b = b;       if64.in_cin = cin; if64.in_sub = sub;
            if32.in_valid = v; if16.in_valid = v; if64.in_valid = v;
            if32.out_ready = r; if16.out_ready = r; if64.out_ready = r;
            @(posedge clk);
            #1;
        end
        if32.in_valid = 1'b0; if16.in_valid = 1'b0; if64.in_valid = 1'b0;
        if32.out_ready = 1'b1; if16.out_ready = 1'b1; if64.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          pat [4];
        logic [31:0] got [$];
        int          sent, held, acc, xf;

        rst = 1'b1;
        if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_cin = 1'b0; if32.in_sub = 1'b0;
        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0; if16.in_sub = 1'b0;
        if64.in_valid = 1'b0; if64.in_a = '0; if64.in_b = '0; if64.in_cin = 1'b0; if64.in_sub = 1'b0;
        if32.out_ready = 1'b1; if16.out_ready = 1'b1; if64.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_out_sum",   64'(if32.out_sum), 64'd0);
        check("rst_out_cout",  64'(if32.out_cout), 64'd0);
        check("rst_out_ovf",   64'(if32.out_ovf), 64'd0);
        check("rst_out_zero",  64'(if32.out_zero), 64'd1);
        check("rst_w64_zero",  64'(if64.out_zero), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready32", 64'(if32.in_ready), 64'd1);
        check("post_rst_in_ready16", 64'(if16.in_ready), 64'd1);
        check("post_rst_in_ready64", 64'(if64.in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_one32("add_wrap",   32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one32("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one32("sub_borrow", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_one32("sub_neg",    32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: consumer ready pattern 1,0,0,1 against a continuous producer.
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0;
        held = 0;
        for (int c = 0; c < 200 && got.size() < 10; c++) begin
            if32.out_ready = pat[c % 4];
            if32.in_valid  = (sent < 10);
            if32.in_a      = 32'(sent);
            if32.in_b      = 32'h100;
            if32.in_cin    = 1'b0;
            if32.in_sub    = 1'b0;
            @(negedge clk);
            check("bp_in_ready", 64'(if32.in_ready), 64'((held < 4) || if32.out_ready));
            acc = int'(if32.in_valid && if32.in_ready);
            xf  = int'(if32.out_valid && if32.out_ready);
            if (xf != 0) got.push_back(if32.out_sum);
            @(posedge clk);
            #1;
            held += acc - xf;
            sent += acc;
        end
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b1;
        check("bp_count", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("bp_data%0d", i), 64'(got[i]), 64'(i + 32'h100));
        end

        // Asynchronous reset with three beats in flight.
        if32.out_ready = 1'b0;
        send32(32'h1, 32'h1, 1'b0, 1'b0);
        send32(32'h2, 32'h2, 1'b0, 1'b0);
        send32(32'h3, 32'h3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(if32.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(if32.out_valid), 64'd0);
        check("async_rst_sum",   64'(if32.out_sum), 64'd0);
        check("async_rst_zero",  64'(if32.out_zero), 64'd1);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        if32.out_ready = 1'b1;
        outs32         = 0;
        run_one32("after_rst", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("only_output", 64'(outs32), 64'd1);

        lat_en = 1'b1;
        rand_phase(300, 1'b0);
        lat_en = 1'b0;
        rand_phase(300, 1'b1);

        check("drain_w32", 64'(q0.size()), 64'd0);
        check("drain_w16", 64'(q1.size()), 64'd0);
        check("drain_w64", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
